// File: rtl/rv_mem_arbiter_pkg.sv
// Shared definitions for the RV32 unified-memory arbiter (package my_pkg).
// Holds bus widths, the memory access-size encoding, the arbiter state type
// and the default fetch starvation threshold.
package my_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // Access size/sign encoding shared by the MEM stage and the memory port
  localparam logic [2:0] MEM_OP_BYTE   = 3'b000;
  localparam logic [2:0] MEM_OP_HALF   = 3'b001;
  localparam logic [2:0] MEM_OP_WORD   = 3'b010;
  localparam logic [2:0] MEM_OP_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_OP_HALF_U = 3'b101;

  // Lost arbitrations a fetch tolerates before it is forced through
  localparam int MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around rv_mem_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory view.
interface rv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = my_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_kill;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [2:0]            dm_op;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ack;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            mem_op;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_op, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    output mem_req, mem_we, mem_op, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_op, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_op, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/rv_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// One transaction at a time: IDLE arbitrates and latches a command, SERVE_D /
// SERVE_I hold it on the memory port until mem_ack, then return to IDLE.
// Data has fixed priority over fetch. Optional build macro
// RV_MEM_ARB_STARVE_GUARD_EN adds a wait counter that forces a fetch grant
// after MAX_WAIT consecutive losses to data.
module rv_mem_arbiter
  import my_pkg::*;
#(
  parameter int ADDR_WIDTH = my_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int MAX_WAIT   = my_pkg::MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  rv_mem_arbiter_if.slave   bus,
  output logic              busy
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("rv_mem_arbiter: MAX_WAIT must be within 1..15");
  end

  arb_state_t            state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  active_q, active_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [2:0]            cmd_op_q, cmd_op_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic fetch_live;
  logic win_data;
  logic win_fetch;

  // A fetch that is being killed in the same cycle never competes
  assign fetch_live = bus.if_req & ~bus.if_kill;

`ifdef RV_MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;
  logic       starved;

  assign starved = (wait_q >= MAX_WAIT_CNT);
`endif

  // Pick the winner of this IDLE cycle: data first unless fetch has starved
  always_comb begin
    win_data  = 1'b0;
    win_fetch = 1'b0;
    if (state_q == IDLE) begin
      if (bus.dm_req && fetch_live) begin
`ifdef RV_MEM_ARB_STARVE_GUARD_EN
        if (starved) begin
          win_fetch = 1'b1;
        end else begin
          win_data = 1'b1;
        end
`else
        win_data = 1'b1;
`endif
      end else if (bus.dm_req) begin
        win_data = 1'b1;
      end else if (fetch_live) begin
        win_fetch = 1'b1;
      end
    end
  end

`ifdef RV_MEM_ARB_STARVE_GUARD_EN
  // Count fetch losses to data; any fetch grant or idle fetch side clears it
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      if (!bus.if_req || win_fetch) begin
        wait_d = 4'd0;
      end else if (win_data && fetch_live && wait_q != 4'hF) begin
        wait_d = wait_q + 4'd1;
      end
    end
  end
`endif

  // Next-state, command capture and kill-flag logic
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    active_d    = active_q;
    cmd_we_d    = cmd_we_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (win_data) begin
          state_d     = SERVE_D;
          active_d    = 1'b1;
          cmd_we_d    = bus.dm_we;
          cmd_op_d    = bus.dm_op;
          cmd_addr_d  = bus.dm_addr;
          cmd_wdata_d = bus.dm_wdata;
        end else if (win_fetch) begin
          state_d     = SERVE_I;
          active_d    = 1'b1;
          cmd_we_d    = 1'b0;
          cmd_op_d    = MEM_OP_WORD;
          cmd_addr_d  = bus.if_addr;
          cmd_wdata_d = '0;
        end
      end
      SERVE_D: begin
        if (bus.mem_ack) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      SERVE_I: begin
        if (bus.if_kill) begin
          kill_d = 1'b1;
        end
        if (bus.mem_ack) begin
          state_d  = IDLE;
          active_d = 1'b0;
          kill_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        active_d = 1'b0;
        kill_d   = 1'b0;
      end
    endcase
  end

  // State and command register; reset drops the memory request at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      active_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_op_q    <= 3'b000;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      active_q    <= active_d;
      cmd_we_q    <= cmd_we_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

`ifdef RV_MEM_ARB_STARVE_GUARD_EN
  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign bus.mem_req   = active_q;
  assign bus.mem_we    = cmd_we_q;
  assign bus.mem_op    = cmd_op_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;
  assign busy          = active_q;

  // Acks follow mem_ack in the matching state; a killed fetch stays silent
  assign bus.dm_ack   = (state_q == SERVE_D) & bus.mem_ack;
  assign bus.if_ack   = (state_q == SERVE_I) & bus.mem_ack & ~kill_q & ~bus.if_kill;
  assign bus.dm_rdata = bus.dm_ack ? bus.mem_rdata : '0;
  assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Randomized scoreboard bench for rv_mem_arbiter. A transaction-level model
// predicts every memory issue and every requester ack; a separate monitor
// pops those predictions when the DUT presents mem_req / if_ack / dm_ack.
// Build with RV_MEM_ARB_STARVE_GUARD_EN to check the starvation guard.
`timescale 1ns/1ps
module tb_rv_mem_arbiter;
  import my_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAXW     = 4;
  localparam int STALLMAX = 6;

  typedef struct packed {
    logic          we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          isFetch;
    logic [DW-1:0] rdata;
  } ack_t;

  typedef enum {M_IDLE, M_DATA, M_FETCH} mstate_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  rv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  rv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  cmd_t expMem[$];
  ack_t expAck[$];

  logic [2:0] opTable[5];
  int  dmProb, ifProb, killProb;
  bit  stimOn;
  int  ifAckCount, dmAckCount;

  // Compare one observed value against the model's expectation
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Run random traffic for a number of cycles with given request rates
  task automatic applyStimulus(input int nCycles, input int dmP, input int ifP, input int killP);
    dmProb   = dmP;
    ifProb   = ifP;
    killProb = killP;
    stimOn   = 1'b1;
    repeat (nCycles) @(posedge clk);
  endtask

  // Reference model: one transaction at a time, data before fetch, kill mutes
  mstate_e mState = M_IDLE;
  bit      killed;
  int      waitCnt;
  bit      expBusy;
  bit      ifAckSeen, dmAckSeen;
  bit      wantFetch, grantData, grantFetch;

  always @(negedge clk) begin
    ifAckSeen = bus.if_ack;
    dmAckSeen = bus.dm_ack;
    if (!rst_n) begin
      mState  = M_IDLE;
      killed  = 1'b0;
      waitCnt = 0;
      expBusy = 1'b0;
      expMem.delete();
      expAck.delete();
    end else begin
      expBusy = (mState != M_IDLE);
      case (mState)
        M_IDLE: begin
          wantFetch  = bus.if_req && !bus.if_kill;
          grantData  = 1'b0;
          grantFetch = 1'b0;
          if (bus.dm_req && wantFetch) begin
`ifdef RV_MEM_ARB_STARVE_GUARD_EN
            if (waitCnt >= MAXW) begin
              grantFetch = 1'b1;
            end else begin
              grantData = 1'b1;
              waitCnt++;
            end
`else
            grantData = 1'b1;
`endif
          end else if (bus.dm_req) begin
            grantData = 1'b1;
          end else if (wantFetch) begin
            grantFetch = 1'b1;
          end
`ifdef RV_MEM_ARB_STARVE_GUARD_EN
          if (!bus.if_req || grantFetch) waitCnt = 0;
`endif
          if (grantData) begin
            expMem.push_back('{bus.dm_we, bus.dm_op, bus.dm_addr, bus.dm_wdata});
            mState = M_DATA;
          end else if (grantFetch) begin
            expMem.push_back('{1'b0, MEM_OP_WORD, bus.if_addr, {DW{1'b0}}});
            mState = M_FETCH;
            killed = 1'b0;
          end
        end
        M_DATA: begin
          if (bus.mem_ack) begin
            expAck.push_back('{1'b0, bus.mem_rdata});
            mState = M_IDLE;
          end
        end
        M_FETCH: begin
          if (bus.if_kill) killed = 1'b1;
          if (bus.mem_ack) begin
            if (!killed) expAck.push_back('{1'b1, bus.mem_rdata});
            killed = 1'b0;
            mState = M_IDLE;
          end
        end
        default: mState = M_IDLE;
      endcase
    end
  end

  // Monitor: pops predictions whenever the DUT issues or acknowledges
  bit   prevReq;
  bit   haveCmd;
  cmd_t curCmd;
  ack_t gotAck;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      checkOutput("rst_mem_req", bus.mem_req, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_if_ack", bus.if_ack, 0);
      checkOutput("rst_dm_ack", bus.dm_ack, 0);
      checkOutput("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      prevReq = 1'b0;
      haveCmd = 1'b0;
    end else begin
      checkOutput("busy", busy, expBusy);
      checkOutput("mem_req", bus.mem_req, expBusy);
      checkOutput("ack_overlap", bus.if_ack & bus.dm_ack, 0);
      if (bus.mem_req && !prevReq) begin
        if (expMem.size() == 0) begin
          checkOutput("mem_issue_unexpected", bus.mem_req, 0);
          haveCmd = 1'b0;
        end else begin
          curCmd  = expMem.pop_front();
          haveCmd = 1'b1;
        end
      end
      if (bus.mem_req && haveCmd) begin
        checkOutput("mem_addr", bus.mem_addr, curCmd.addr);
        checkOutput("mem_we", bus.mem_we, curCmd.we);
        checkOutput("mem_op", bus.mem_op, curCmd.op);
        if (curCmd.we) checkOutput("mem_wdata", bus.mem_wdata, curCmd.wdata);
      end
      if (!bus.mem_req) haveCmd = 1'b0;
      prevReq = bus.mem_req;
      if (bus.if_ack || bus.dm_ack) begin
        if (bus.if_ack) ifAckCount++;
        if (bus.dm_ack) dmAckCount++;
        if (expAck.size() == 0) begin
          checkOutput("ack_unexpected", {bus.if_ack, bus.dm_ack}, 0);
        end else begin
          gotAck = expAck.pop_front();
          checkOutput("ack_is_fetch", bus.if_ack, gotAck.isFetch);
          checkOutput("ack_is_data", bus.dm_ack, !gotAck.isFetch);
          checkOutput("ack_rdata", gotAck.isFetch ? bus.if_rdata : bus.dm_rdata, gotAck.rdata);
        end
      end
      checkOutput("ack_missing", expAck.size(), 0);
      expAck.delete();
    end
  end

  // Memory model: random stall per access, occasional spurious idle acks
  bit inflight;
  int memDelay, memCnt;

  always @(posedge clk) begin
    #1;
    bus.mem_rdata = $urandom;
    if (!rst_n) begin
      inflight    = 1'b0;
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (!inflight) begin
        inflight = 1'b1;
        memDelay = $urandom_range(0, STALLMAX);
        memCnt   = 0;
      end
      if (memCnt == memDelay) begin
        bus.mem_ack = 1'b1;
        inflight    = 1'b0;
      end else begin
        bus.mem_ack = 1'b0;
        memCnt++;
      end
    end else begin
      inflight    = 1'b0;
      bus.mem_ack = ($urandom_range(0, 15) == 0);
    end
  end

  // Data requester: holds each request until its ack, then may issue again
  bit dmActive;

  always @(posedge clk) begin
    #1;
    if (dmActive && dmAckSeen) begin
      dmActive   = 1'b0;
      bus.dm_req = 1'b0;
    end
    if (!dmActive && stimOn && $urandom_range(0, 99) < dmProb) begin
      dmActive     = 1'b1;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_op    = opTable[$urandom_range(0, 4)];
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
    end
  end

  // Fetch requester: holds until ack, occasionally kills and abandons
  bit ifActive, ifKilling;

  always @(posedge clk) begin
    #1;
    bus.if_kill = 1'b0;
    if (ifKilling) begin
      ifKilling  = 1'b0;
      ifActive   = 1'b0;
      bus.if_req = 1'b0;
    end else if (ifActive && ifAckSeen) begin
      ifActive   = 1'b0;
      bus.if_req = 1'b0;
    end else if (ifActive && $urandom_range(0, 99) < killProb) begin
      bus.if_kill = 1'b1;
      ifKilling   = 1'b1;
    end
    if (!ifActive && stimOn && $urandom_range(0, 99) < ifProb) begin
      ifActive    = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    end
  end

  bit found;
  bit drained;

  initial begin
    opTable[0] = MEM_OP_BYTE;
    opTable[1] = MEM_OP_HALF;
    opTable[2] = MEM_OP_WORD;
    opTable[3] = MEM_OP_BYTE_U;
    opTable[4] = MEM_OP_HALF_U;
    stimOn       = 1'b0;
    dmProb       = 0;
    ifProb       = 0;
    killProb     = 0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_kill  = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_op    = 3'b000;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1500, 30, 60, 5);

    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #3;
      if (mState == M_DATA) found = 1'b1;
    end
    checkOutput("rst_wait_serve_d", found, 1);
    if (found) begin
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_mem_req", bus.mem_req, 0);
      checkOutput("async_rst_dm_ack", bus.dm_ack, 0);
      checkOutput("async_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
    end

    applyStimulus(1500, 95, 90, 2);

    stimOn = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      @(posedge clk);
      if (!dmActive && !ifActive && !ifKilling) drained = 1'b1;
    end
    repeat (20) @(posedge clk);
    checkOutput("drain_done", drained, 1);
    checkOutput("drain_mem_queue", expMem.size(), 0);
    checkOutput("saw_if_acks", (ifAckCount > 0), 1);
    checkOutput("saw_dm_acks", (dmAckCount > 0), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Single-port memory arbiter for the 5-stage RV32 pipeline.
- Shares one unified instruction/data memory port between two requesters: fetch (IF, read-only) and data access (MEM stage, load/store).
- Sequences each access through a small FSM with a one-transaction-at-a-time policy.
- Returns per-requester acknowledges, which the hazard unit uses to build stallF/stallM.

Parameters:
- ADDR_WIDTH, my_pkg::ADDR_WIDTH (32): address width.
- DATA_WIDTH, my_pkg::DATA_WIDTH (32): data width.
- MAX_WAIT, 4: fetch starvation threshold in lost arbitrations; used only with the optional feature; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack or if_kill
- if_addr  in  ADDR_WIDTH  fetch address
- if_kill  in  1  abandon the current or pending fetch (branch taken)
- if_ack  out  1  fetch complete; if_rdata valid this cycle
- if_rdata  out  DATA_WIDTH  fetched instruction
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_op  in  3  my_pkg mem_op encoding (byte/half/word, sign)
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_ack  out  1  data access complete; dm_rdata valid for loads
- dm_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  request to memory; held until mem_ack
- mem_we  out  1  write enable
- mem_op  out  3  access size/sign
- mem_addr  out  ADDR_WIDTH  address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  memory completion pulse; mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock/reset:
  - Single clock clk.
  - rst_n is asynchronous, active-low.
  - During reset, all outputs are 0, FSM is in IDLE, and the kill flag and wait counter are 0.
  - Reset mid-transaction drops mem_req immediately and discards the outstanding access; the memory model must tolerate this.
- FSM states: IDLE, SERVE_D, SERVE_I.
- IDLE:
  - Samples requests each cycle.
  - dm_req has fixed priority over if_req.
  - An if_req with if_kill high in the same cycle is ignored.
  - On a winning request, the command fields (we/op/addr/wdata) are latched into a registered command. The next state is SERVE_D or SERVE_I.
  - Fetch commands force we=0 and op=word.
- SERVE_x:
  - mem_req=1 and mem_* driven from the latched command, stable until mem_ack.
  - On mem_ack: ack is driven combinationally (dm_ack or if_ack = mem_ack in the matching state), and rdata passes through mem_rdata. The FSM returns to IDLE next cycle.
- Latency: minimum request-to-ack is 2 cycles (arbitration cycle plus a same-cycle memory ack). Back-to-back accesses have a 1-cycle IDLE bubble.
- Requester protocol: a requester may deassert or change its request on the cycle after ack. A new request is sampled in the following IDLE cycle, so there is no double-issue.
- Kill:
  - if_kill asserted in SERVE_I sets a kill flag.
  - The memory transaction completes normally, but if_ack is suppressed on mem_ack.
  - The kill flag clears on return to IDLE.
  - if_kill in SERVE_D has no effect.
- Simultaneous dm_req and if_req in IDLE: data wins; fetch stays pending and is served next.
- If mem_ack arrives in IDLE (spurious), it is ignored and no ack is generated.
- busy = (state != IDLE).
- if_ack and dm_ack are never high in the same cycle.

Optional Feature:
- Macro: RV_MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A 4-bit wait counter increments each time if_req loses arbitration to dm_req in IDLE.
  - When the counter reaches MAX_WAIT, the next IDLE arbitration with both requests pending grants fetch.
  - The counter clears on any fetch grant, and when if_req is low in IDLE.
- Without the macro: pure fixed priority (data over fetch); no counter logic is present.

Decomposition:
- my_pkg gains:
  - ADDR_WIDTH and DATA_WIDTH (existing).
  - Typedef arb_state_t {IDLE, SERVE_D, SERVE_I}.
  - MEM_OP_WORD, the constant used to force fetch size.
  - Default MAX_WAIT constant.
- No sub-module; the FSM, command register and counter are a single module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, memory acks 1 cycle after mem_req -> mem_req rises in cycle 1 with mem_addr=0x100, mem_we=0; if_ack=1 with if_rdata=mem_rdata in cycle 2; busy low in cycle 3.
- Collision: dm_req(load 0x2000) and if_req(0x104) in the same cycle -> mem_addr=0x2000 first and dm_ack first; fetch issued after one IDLE bubble; if_ack follows; acks never overlap.
- Kill in flight: fetch 0x108 in SERVE_I, if_kill pulsed, mem_ack 3 cycles later -> no if_ack; FSM returns to IDLE; a subsequent fetch of 0x200 proceeds normally.
- Store: dm_we=1, dm_op=byte, dm_addr=0x3003, dm_wdata=0xAB -> mem_we=1, mem_op=byte, mem_wdata=0xAB held stable for a 5-cycle memory stall; dm_ack on mem_ack.
- Reset mid-op: rst_n low during SERVE_D -> mem_req=0, dm_ack=0, busy=0 asynchronously; after release, pending requests are arbitrated cleanly from IDLE.
- Starvation (macro defined, MAX_WAIT=4): dm_req held continuously with if_req high -> fetch granted on the 5th arbitration. Without the macro, fetch is never granted while dm_req stays high.
